// File: rtl/xnor_popcnt_acc_pkg.sv
// Shared types and sizing helpers for the BNN xnor/popcount accumulator.
package lpa_bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int acc_width(input int bw, input int beats);
        return $clog2(bw * beats + 1);
    endfunction

endpackage

// File: rtl/xnor_popcnt_acc_popcount.sv
// Combinational population count of a BW-bit word.
module popcount #(
    parameter  int BW = 8,
    localparam int CW = $clog2(BW + 1)
) (
    input  logic [BW-1:0] bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < BW; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/xnor_popcnt_acc.sv
// Streaming binary dot-product: popcount(act ~^ wgt) summed over BEATS beats.
// XNOR_ACC_AND_MODE_EN adds i_mode to select an AND (unipolar) product.
module xnor_popcnt_acc
    import lpa_bnn_pkg::*;
#(
    parameter  int BW    = 8,
    parameter  int BEATS = 32,
    localparam int ACC_W = acc_width(BW, BEATS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [BW-1:0]    i_act,
    input  logic [BW-1:0]    i_wgt,
`ifdef XNOR_ACC_AND_MODE_EN
    input  logic             i_mode,
`endif
    input  logic [ACC_W-1:0] i_thresh,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_bit
);

    localparam int PC_W  = $clog2(BW + 1);
    localparam int CNT_W = $clog2(BEATS + 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ACC_W-1:0]  acc, acc_n;
    logic [ACC_W-1:0]  thresh_r, thresh_n;
    logic [BW-1:0]     prod;
    logic [PC_W-1:0]   pc;
    logic              accept;

`ifdef XNOR_ACC_AND_MODE_EN
    logic mode_r, mode_n, use_and;

    // Only the first beat of a product reads i_mode; later beats use the held copy.
    assign use_and = (state == ACC) ? mode_r : i_mode;
    assign prod    = use_and ? (i_act & i_wgt) : (i_act ~^ i_wgt);
`else
    assign prod    = i_act ~^ i_wgt;
`endif

    popcount #(.BW(BW)) u_popcount (
        .bits  (prod),
        .count (pc)
    );

    assign o_ready = (state == DONE) ? i_ready : 1'b1;
    assign accept  = i_valid && o_ready;
    assign o_valid = (state == DONE);
    assign o_sum   = o_valid ? acc : '0;
    assign o_bit   = o_valid && (acc >= thresh_r);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        thresh_n = thresh_r;
`ifdef XNOR_ACC_AND_MODE_EN
        mode_n   = mode_r;
`endif
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    acc_n    = ACC_W'(pc);
                    cnt_n    = CNT_W'(1);
                    thresh_n = i_thresh;
`ifdef XNOR_ACC_AND_MODE_EN
                    mode_n   = i_mode;
`endif
                    state_n  = ACC;
                end else if (state == DONE && i_ready) begin
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_n = acc + ACC_W'(pc);
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BEATS - 1)) begin
                        state_n = DONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            thresh_r <= '0;
`ifdef XNOR_ACC_AND_MODE_EN
            mode_r   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            thresh_r <= thresh_n;
`ifdef XNOR_ACC_AND_MODE_EN
            mode_r   <= mode_n;
`endif
        end
    end

endmodule

// File: tb/tb_xnor_popcnt_acc.sv
// Self-checking bench for xnor_popcnt_acc (BW=8, BEATS=4).
module tb_xnor_popcnt_acc;

    localparam int BW    = 8;
    localparam int BEATS = 4;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b1;
    logic [BW-1:0] i_act = '0;
    logic [BW-1:0] i_wgt = '0;
    logic [AW-1:0] i_thresh = '0;
`ifdef XNOR_ACC_AND_MODE_EN
    logic          i_mode = 1'b0;
`endif
    logic          o_ready;
    logic          o_valid;
    logic [AW-1:0] o_sum;
    logic          o_bit;

    xnor_popcnt_acc #(.BW(BW), .BEATS(BEATS)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_act    (i_act),
        .i_wgt    (i_wgt),
`ifdef XNOR_ACC_AND_MODE_EN
        .i_mode   (i_mode),
`endif
        .i_thresh (i_thresh),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
        .o_bit    (o_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][7:0] act;
        logic [3:0][7:0] wgt;
        logic [AW-1:0]   thr;
        logic            mode;
        logic [AW-1:0]   sum;
        logic            bitv;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] sum;
        logic          bitv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[6];
    vec_t mv[4];
    vec_t zv;
    int   total = 0;
    int   bad = 0;
    int   first_waits;
    int   w;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result got=%0d want=none", o_sum);
                end else begin
                    mon_e = sb.pop_front();
                    check("sum", 32'(o_sum), 32'(mon_e.sum));
                    check("bit", 32'(o_bit), 32'(mon_e.bitv));
                end
            end else if (!o_valid) begin
                check("idle_zero", {25'd0, o_sum, o_bit}, 32'd0);
            end
        end
    end

    task automatic drive_beat(input logic [7:0] a, input logic [7:0] wt,
                              input logic [AW-1:0] t, output int waits);
        logic ok;
        ok = 1'b0;
        waits = 0;
        i_valid  = 1'b1;
        i_act    = a;
        i_wgt    = wt;
        i_thresh = t;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            ok = o_ready;
            @(posedge clk);
            #1;
            waits++;
            if (ok) break;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=none want=accept");
        end
        i_valid  = 1'b0;
        i_act    = 8'($urandom);
        i_wgt    = 8'($urandom);
        i_thresh = AW'($urandom);
    endtask

    task automatic run_product(input vec_t p, input bit gaps, input bit push);
        int wt;
        if (push) sb.push_back({p.sum, p.bitv});
`ifdef XNOR_ACC_AND_MODE_EN
        i_mode = p.mode;
`endif
        for (int b = 0; b < BEATS; b++) begin
            drive_beat(p.act[b], p.wgt[b], (b == 0) ? p.thr : AW'($urandom), wt);
            if (b == 0) first_waits = wt;
`ifdef XNOR_ACC_AND_MODE_EN
            i_mode = ~p.mode;
`endif
            if (gaps && b < BEATS - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        tbl[0] = '{act: {4{8'hFF}}, wgt: {4{8'hFF}}, thr: 6'd16, mode: 1'b0,
                   sum: 6'd32, bitv: 1'b1};
        tbl[1] = '{act: {8'h03, 8'hF0, 8'hFF, 8'hA5},
                   wgt: {8'hFF, 8'hFF, 8'h00, 8'hA5}, thr: 6'd15, mode: 1'b0,
                   sum: 6'd14, bitv: 1'b0};
        tbl[2] = '{act: {4{8'h00}}, wgt: {4{8'hFF}}, thr: 6'd0, mode: 1'b0,
                   sum: 6'd0, bitv: 1'b1};
        tbl[3] = '{act: {4{8'h5A}}, wgt: {4{8'h5A}}, thr: 6'd32, mode: 1'b0,
                   sum: 6'd32, bitv: 1'b1};
        tbl[4] = '{act: {4{8'hFF}}, wgt: {4{8'hFF}}, thr: 6'd33, mode: 1'b0,
                   sum: 6'd32, bitv: 1'b0};
        tbl[5] = '{act: {4{8'h0F}}, wgt: {4{8'hFF}}, thr: 6'd17, mode: 1'b0,
                   sum: 6'd16, bitv: 1'b0};
        zv     = '{act: {4{8'h00}}, wgt: {4{8'hFF}}, thr: 6'd5, mode: 1'b0,
                   sum: 6'd0, bitv: 1'b0};
        mv[0]  = '{act: {4{8'h0F}}, wgt: {4{8'hFF}}, thr: 6'd16, mode: 1'b1,
                   sum: 6'd16, bitv: 1'b1};
        mv[1]  = '{act: {4{8'h0F}}, wgt: {4{8'hFF}}, thr: 6'd16, mode: 1'b0,
                   sum: 6'd16, bitv: 1'b1};
        mv[2]  = '{act: {4{8'h00}}, wgt: {4{8'h00}}, thr: 6'd1, mode: 1'b1,
                   sum: 6'd0, bitv: 1'b0};
        mv[3]  = '{act: {4{8'h00}}, wgt: {4{8'h00}}, thr: 6'd1, mode: 1'b0,
                   sum: 6'd32, bitv: 1'b1};

        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_sum", 32'(o_sum), 32'd0);
        check("rst_bit", 32'(o_bit), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("rst_ready", 32'(o_ready), 32'd1);

        // Back-to-back table products: next product starts in the DONE cycle.
        for (int i = 0; i < 6; i++) begin
            run_product(tbl[i], 1'b0, 1'b1);
            check("latency_valid", 32'(o_valid), 32'd1);
            if (i > 0) check("stream_no_bubble", 32'(first_waits), 32'd1);
        end
        repeat (3) @(posedge clk);
        #1;

        i_ready = 1'b0;
        run_product(tbl[0], 1'b0, 1'b1);
        check("bp_valid", 32'(o_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(o_valid), 32'd1);
            check("bp_hold_sum", 32'(o_sum), 32'd32);
            check("bp_hold_ready", 32'(o_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        run_product(tbl[1], 1'b0, 1'b1);
        check("bp_restart_no_bubble", 32'(first_waits), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        run_product(tbl[0], 1'b1, 1'b1);
        check("gap_latency_valid", 32'(o_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        i_ready = 1'b0;
        run_product(tbl[0], 1'b0, 1'b0);
        check("pre_rst_valid", 32'(o_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_sum", 32'(o_sum), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        i_ready = 1'b1;

        drive_beat(8'hFF, 8'hFF, 6'd3, w);
        drive_beat(8'hFF, 8'hFF, 6'd3, w);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_sum", 32'(o_sum), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        run_product(zv, 1'b0, 1'b1);
        check("post_rst_valid", 32'(o_valid), 32'd1);

`ifdef XNOR_ACC_AND_MODE_EN
        for (int i = 0; i < 4; i++) begin
            run_product(mv[i], 1'b0, 1'b1);
        end
`endif

        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        #1;
        check("drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
